// File: rtl/eth_header_builder_if.sv
// Handshake bundle between the TX scheduler, the header builder and the MAC/FCS stage.
// Groups the metadata record, the payload byte stream and the framed output byte stream.
// slave: the builder's view. master: the surrounding logic that feeds and drains it.
interface eth_header_builder_if;
  // Per-frame L2 metadata record.
  logic        meta_valid;
  logic        meta_ready;
  logic [47:0] meta_dest_mac;
  logic [47:0] meta_src_mac;
  logic [15:0] meta_ethertype;
  logic        meta_vlan_present;
  logic [11:0] meta_vlan_id;
  // Payload byte stream.
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        pl_ready;
  // Framed output byte stream.
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_start;
  logic        tx_last;

  modport slave (
    input  meta_valid, meta_dest_mac, meta_src_mac, meta_ethertype,
           meta_vlan_present, meta_vlan_id,
    output meta_ready,
    input  pl_data, pl_valid, pl_last,
    output pl_ready,
    output tx_data, tx_valid, tx_start, tx_last,
    input  tx_ready
  );

  modport master (
    output meta_valid, meta_dest_mac, meta_src_mac, meta_ethertype,
           meta_vlan_present, meta_vlan_id,
    input  meta_ready,
    output pl_data, pl_valid, pl_last,
    input  pl_ready,
    input  tx_data, tx_valid, tx_start, tx_last,
    output tx_ready
  );
endinterface

// File: rtl/eth_header_builder.sv
// Ethernet TX header builder: metadata record -> header bytes, then payload, then zero pad to MIN_LEN.
// Latency: record accepted at edge N, header byte 0 presented in cycle N+1; one idle cycle between frames.
// Backpressure: tx_ready stalls header/pad bytes (held stable); in payload tx_ready passes straight to pl_ready.
// Ports: clk (rising edge), rst (synchronous, active high), bus (slave view of eth_header_builder_if):
//   meta_* record in with meta_valid/meta_ready, pl_* payload bytes in with pl_valid/pl_ready/pl_last,
//   tx_* frame bytes out with tx_valid/tx_ready, tx_start on byte 0 and tx_last on the final byte.
module eth_header_builder #(
  parameter logic [15:0] TPID    = 16'h8100,
  parameter bit          PAD_EN  = 1'b1,
  parameter int          MIN_LEN = 60
) (
  input  logic clk,
  input  logic rst,
  eth_header_builder_if.slave bus
);

  localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);
  localparam logic [15:0] PAD_LAST  = 16'(MIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;

  state_t      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [47:0] dest_q, src_q;
  logic [15:0] etype_q;
  logic        vlan_q;
  logic [11:0] vid_q;
  logic [4:0]  hdr_len_q;

  logic        meta_rdy, pl_rdy, tx_vld, tx_sof, tx_eof;
  logic [7:0]  tx_dat, hdr_byte;
  logic        hs, hdr_done, pad_needed, pad_done;
  logic [15:0] cnt_inc;

  assign hs         = tx_vld && bus.tx_ready;
  assign hdr_done   = (byte_cnt_q == ({11'd0, hdr_len_q} - 16'd1));
  // Pad only if this payload byte would leave the frame short of MIN_LEN.
  assign pad_needed = PAD_EN && (({1'b0, byte_cnt_q} + 17'd1) < MIN_LEN_W);
  assign pad_done   = (byte_cnt_q == PAD_LAST);
  // Counter saturates rather than wrapping on absurdly long payloads.
  assign cnt_inc    = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.meta_valid) state_d = HDR;
      HDR:     if (hs && hdr_done) state_d = PAYLOAD;
      PAYLOAD: if (hs && bus.pl_last) state_d = pad_needed ? PAD : IDLE;
      PAD:     if (hs && pad_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Everything is forced low while rst is high so an aborted frame
  // neither completes a handshake nor drains payload during the reset cycle.
  always_comb begin
    meta_rdy = 1'b0;
    pl_rdy   = 1'b0;
    tx_vld   = 1'b0;
    tx_dat   = 8'h00;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: meta_rdy = 1'b1;
        HDR: begin
          tx_vld = 1'b1;
          tx_dat = hdr_byte;
          tx_sof = (byte_cnt_q == 16'd0);
        end
        PAYLOAD: begin
          tx_vld = bus.pl_valid;
          tx_dat = bus.pl_data;
          pl_rdy = bus.tx_ready;
          tx_eof = bus.pl_valid && bus.pl_last && !pad_needed;
        end
        PAD: begin
          tx_vld = 1'b1;
          tx_eof = pad_done;
        end
        default: ;
      endcase
    end
  end

  // Header byte selected by the running byte count; bytes 14..17 are only
  // reached when a tag is present.
  always_comb begin
    hdr_byte = 8'h00;
    case (byte_cnt_q[4:0])
      5'd0:  hdr_byte = dest_q[47:40];
      5'd1:  hdr_byte = dest_q[39:32];
      5'd2:  hdr_byte = dest_q[31:24];
      5'd3:  hdr_byte = dest_q[23:16];
      5'd4:  hdr_byte = dest_q[15:8];
      5'd5:  hdr_byte = dest_q[7:0];
      5'd6:  hdr_byte = src_q[47:40];
      5'd7:  hdr_byte = src_q[39:32];
      5'd8:  hdr_byte = src_q[31:24];
      5'd9:  hdr_byte = src_q[23:16];
      5'd10: hdr_byte = src_q[15:8];
      5'd11: hdr_byte = src_q[7:0];
      5'd12: hdr_byte = vlan_q ? TPID[15:8] : etype_q[15:8];
      5'd13: hdr_byte = vlan_q ? TPID[7:0]  : etype_q[7:0];
      5'd14: hdr_byte = {4'h0, vid_q[11:8]};   // PCP=0, DEI=0
      5'd15: hdr_byte = vid_q[7:0];
      5'd16: hdr_byte = etype_q[15:8];
      5'd17: hdr_byte = etype_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q == IDLE) begin
      if (bus.meta_valid) byte_cnt_d = 16'd0;
    end else if (hs) begin
      byte_cnt_d = cnt_inc;
    end
  end

  // Byte counter and captured metadata; the record is frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= 16'd0;
      dest_q     <= 48'd0;
      src_q      <= 48'd0;
      etype_q    <= 16'd0;
      vlan_q     <= 1'b0;
      vid_q      <= 12'd0;
      hdr_len_q  <= 5'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      if (state_q == IDLE && bus.meta_valid) begin
        dest_q    <= bus.meta_dest_mac;
        src_q     <= bus.meta_src_mac;
        etype_q   <= bus.meta_ethertype;
        vlan_q    <= bus.meta_vlan_present;
        vid_q     <= bus.meta_vlan_id;
        hdr_len_q <= bus.meta_vlan_present ? 5'd18 : 5'd14;
      end
    end
  end

  assign bus.meta_ready = meta_rdy;
  assign bus.pl_ready   = pl_rdy;
  assign bus.tx_valid   = tx_vld;
  assign bus.tx_data    = tx_dat;
  assign bus.tx_start   = tx_sof;
  assign bus.tx_last    = tx_eof;

endmodule

// File: doc/eth_header_builder.md
# eth_header_builder

Transmit-side counterpart of the receive metadata path: accepts one per-frame L2 metadata record (MACs, EtherType, optional VLAN) over a valid/ready handshake and serializes a complete Ethernet frame byte stream. The stream is the built header, followed by a forwarded payload stream, followed by optional zero padding up to a minimum length. Sits between the TX scheduler and the MAC/FCS inserter; FCS is not generated here.

## Interface
- `TPID`, 16'h8100: TPID inserted when a VLAN tag is requested.
- `PAD_EN`, 1: when 1, short frames are zero-padded to `MIN_LEN`.
- `MIN_LEN`, 60: minimum frame length in bytes, header included, FCS excluded. Legal range 18..1518.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `meta_valid` in 1: metadata record valid.
- `meta_ready` out 1: builder can accept a record.
- `meta_dest_mac` in 48: destination MAC, byte 0 = bits [47:40].
- `meta_src_mac` in 48: source MAC.
- `meta_ethertype` in 16: EtherType/length field.
- `meta_vlan_present` in 1: insert an 802.1Q tag.
- `meta_vlan_id` in 12: VID for the tag.
- `pl_data` in 8: payload byte.
- `pl_valid` in 1: payload byte valid.
- `pl_last` in 1: final payload byte.
- `pl_ready` out 1: payload byte consumed.
- `tx_data` out 8: output byte.
- `tx_valid` out 1: output byte valid.
- `tx_ready` in 1: downstream accepts the byte.
- `tx_start` out 1: marks frame byte 0.
- `tx_last` out 1: marks the final frame byte.

## Operation
- **FSM states:** IDLE, HDR, PAYLOAD, PAD.
- **IDLE**
  - `meta_ready`=1.
  - On `meta_valid`, capture all `meta_*` fields into internal registers and set `hdr_len` = 18 if the VLAN tag is requested, otherwise 14.
  - Clear `byte_cnt` (16-bit) and go to HDR.
- **HDR**
  - `tx_valid`=1; `tx_data` = header byte[`byte_cnt`].
  - Untagged header bytes: 0–5 dest MAC (MSB first), 6–11 src MAC, 12–13 EtherType.
  - Tagged header bytes: 12–13 `TPID`, 14–15 TCI = {PCP=3'b0, DEI=1'b0, VID}, 16–17 EtherType.
  - Each handshake (`tx_valid && tx_ready`) increments `byte_cnt`.
  - The handshake on byte `hdr_len`-1 moves to PAYLOAD.
- **PAYLOAD**
  - `tx_data`=`pl_data`, `tx_valid`=`pl_valid`, `pl_ready`=`tx_ready`.
  - Each handshake increments `byte_cnt`.
  - On the handshake carrying `pl_last`:
    - If `PAD_EN` and `byte_cnt`+1 < `MIN_LEN`: go to PAD; `tx_last`=0 on this byte.
    - Otherwise: `tx_last`=1 on this byte and go to IDLE.
- **PAD**
  - `tx_valid`=1, `tx_data`=8'h00.
  - `tx_last`=1 when `byte_cnt`==`MIN_LEN`-1; that handshake goes to IDLE.
- **Per-state outputs**
  - `tx_start`=1 only in HDR with `byte_cnt`==0.
  - `pl_ready`=0 outside PAYLOAD.
  - `meta_ready`=0 outside IDLE.
- **Payload length:** payload is at least 1 byte, because `pl_last` always rides on a data byte.
- **Counter:** `byte_cnt` saturates at 16'hFFFF and does not wrap.
- **Metadata stability:** captured metadata is held for the whole frame; changes on `meta_*` during a frame have no effect.

## Timing
- **Reset values:** while `rst`=1 and on the following edge, state=IDLE and `byte_cnt`=0.
  - Held low: `meta_ready`, `tx_valid`, `tx_start`, `tx_last`, `pl_ready`.
  - `tx_data`=8'h00.
  - Captured metadata registers = 0.
  - `meta_ready` rises in the first cycle after `rst` deasserts.
- **Reset mid-frame:** the frame is aborted. `tx_valid` is low in the next cycle, no `tx_last` is emitted, and payload is not drained.
- **Latency:** metadata accepted at edge N → header byte 0 presented with `tx_valid`=1 in cycle N+1.
- **Output register paths:**
  - `tx_valid`, `tx_data`, `tx_start` and `tx_last` are registered-state-derived in HDR/PAD; there is no combinational path from `tx_ready`.
  - In PAYLOAD the path is a combinational pass-through: `pl_valid`→`tx_valid`, `tx_ready`→`pl_ready`.
- **Backpressure:** while `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_start` and `tx_last` are held stable.
- **Frame-to-frame gap:** the last-byte handshake at edge M gives IDLE in cycle M+1 (`meta_ready`=1). The earliest next `tx_start` is cycle M+2, so there is a one-cycle minimum inter-frame bubble.
- **Simultaneous events:** `meta_valid` held through a busy frame is accepted only once IDLE is reached.

## Test plan
- **Untagged, no padding:** dest 00:11:22:33:44:55, src 66:77:88:99:AA:BB, EtherType 0x0800, 50-byte incrementing payload.
  - Required: 64 bytes; bytes 12–13 = 08 00; `tx_start` on byte 0; `tx_last` only on byte 63.
- **Tagged:** VID 0x123, EtherType 0x86DD, 46-byte payload.
  - Required: bytes 12–17 = 81 00 01 23 86 DD; 64 bytes total; no padding.
- **Short frame padding:** untagged, 10-byte payload.
  - Required: bytes 24–59 = 00; `tx_last` on byte 59; `tx_valid`=1 throughout PAD.
- **Backpressure:**
  - `tx_ready` toggled pseudo-randomly: byte stream identical to the no-stall run, with data held stable during stalls.
  - `pl_valid` gaps in PAYLOAD produce `tx_valid` gaps.
- **Busy handling:** `meta_valid` asserted continuously with a second record.
  - Required: `meta_ready`=0 until the first frame's last handshake; the second frame's byte 0 appears exactly 2 cycles after it.
- **Reset mid-payload:** `rst` asserted for 1 cycle at byte 20.
  - Required: `tx_valid`=0 the next cycle, no `tx_last`, `meta_ready`=1 after `rst` drops, and the next frame is correct.
